// File: rtl/uart_result_streamer.sv
// ============================================================================
// uart_result_streamer
//
// Purpose:
//   Dumps a block of height*width result words from the output memory onto a
//   UART line. After a start strobe the words are read one at a time. Each
//   word is sent as BYTES = ceil(DATA_WIDTH/8) byte frames, least significant
//   byte first. Each frame is a start bit, 8 data bits (LSB first), an
//   optional parity bit and one or two stop bits. An abort request stops the
//   dump cleanly at the next byte-frame boundary.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   start      in   one-cycle dump request, ignored while busy
//   abort      in   stop after the byte frame currently on the line
//   height     in   [DIM_WIDTH]   image rows, sampled when start is accepted
//   width      in   [DIM_WIDTH]   image columns, sampled when start is accepted
//   mem_addr   out  [ADDR_WIDTH]  read address (word index, zero-extended)
//   mem_rd_en  out  read strobe, one per word
//   mem_rdata  in   [DATA_WIDTH]  read data, valid MEM_LATENCY clocks after mem_rd_en
//   tx_serial  out  UART line, idle high
//   busy       out  dump in progress
//   done       out  one-cycle completion pulse
// ============================================================================
module uart_result_streamer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 16,
    parameter int DIM_WIDTH    = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DIM_WIDTH-1:0]  height,
    input  logic [DIM_WIDTH-1:0]  width,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  tx_serial,
    output logic                  busy,
    output logic                  done
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int BYTES   = (DATA_WIDTH + 7) / 8;
    localparam int SHIFT_W = BYTES * 8;
    localparam int COUNT_W = 2 * DIM_WIDTH;
    localparam int BAUD_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int WAIT_W  = $clog2(MEM_LATENCY + 1);
    localparam int BYTE_W  = $clog2(BYTES + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);
    localparam logic              HAS_PARITY = (PARITY != 0);
    localparam logic              PAR_INV    = (PARITY == 2);

    // ------------------------------------------------------------------------
    // Parameter sanity checks, caught while elaborating
    // ------------------------------------------------------------------------
    generate
        if (ADDR_WIDTH < 2 * DIM_WIDTH) begin : g_bad_addr_width
            $error("uart_result_streamer: ADDR_WIDTH must be >= 2*DIM_WIDTH");
        end
        if (MEM_LATENCY < 1) begin : g_bad_latency
            $error("uart_result_streamer: MEM_LATENCY must be >= 1");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_result_streamer: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_result_streamer: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_baud
            $error("uart_result_streamer: CLKS_PER_BIT must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        START,
        DATA,
        PAR,
        STOP,
        DONE
    } state_t;

    state_t               state;
    logic [COUNT_W-1:0]   total;
    logic [COUNT_W-1:0]   word_idx;
    logic [SHIFT_W-1:0]   shift_reg;
    logic [BYTE_W-1:0]    byte_idx;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 par_acc;
    logic                 abort_flag;

    logic [COUNT_W-1:0]   product;
    logic [COUNT_W:0]     next_idx;
    logic                 more_words;
    logic                 baud_end;
    logic                 stop_req;

    // ------------------------------------------------------------------------
    // Helper terms for the FSM. The word count is an unsigned product of the
    // two dimensions at full double width so it can never wrap. The index
    // increment carries one extra bit so the "more words left" test is an
    // honest unsigned compare even at the largest possible image.
    // ------------------------------------------------------------------------
    always_comb begin
        product    = COUNT_W'(height) * COUNT_W'(width);
        next_idx   = {1'b0, word_idx} + (COUNT_W + 1)'(1);
        more_words = (next_idx < {1'b0, total});
        baud_end   = (baud_cnt == BAUD_LAST);
        stop_req   = abort_flag | abort;
    end

    // ------------------------------------------------------------------------
    // Main sequencer. Every output is a register, so each output value is
    // loaded on the edge that enters the state it belongs to: mem_rd_en goes
    // high on entry to FETCH, the start-bit low on entry to START, and so on.
    //
    // Bits are launched from the bottom of shift_reg, which shifts right once
    // per data bit. After 8 shifts the next byte of the word already sits in
    // the low bits, so consecutive bytes need no extra handling. par_acc
    // collects the XOR of the bits as they go out, so it is complete when the
    // last data bit ends and the parity bit can be driven straight from it.
    //
    // An abort request is only acted on where cutting off costs nothing: while
    // still fetching, or at the end of a byte frame's last stop bit. It is
    // remembered in abort_flag until the FSM returns to IDLE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            total      <= '0;
            word_idx   <= '0;
            shift_reg  <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            baud_cnt   <= '0;
            wait_cnt   <= '0;
            par_acc    <= 1'b0;
            abort_flag <= 1'b0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            tx_serial  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (abort && state != IDLE && state != DONE) begin
                abort_flag <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    done      <= 1'b0;
                    mem_rd_en <= 1'b0;
                    if (start) begin
                        total <= product;
                        busy  <= 1'b1;
                        if (product == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            word_idx  <= '0;
                            mem_addr  <= '0;
                            mem_rd_en <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    mem_rd_en <= 1'b0;
                    wait_cnt  <= '0;
                    if (stop_req) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (stop_req) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        shift_reg <= SHIFT_W'(mem_rdata);
                        byte_idx  <= '0;
                        baud_cnt  <= '0;
                        tx_serial <= 1'b0;
                        state     <= START;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                START: begin
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        tx_serial <= shift_reg[0];
                        par_acc   <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= '0;
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (HAS_PARITY) begin
                                tx_serial <= par_acc ^ PAR_INV;
                                state     <= PAR;
                            end else begin
                                tx_serial <= 1'b1;
                                stop_idx  <= 1'b0;
                                state     <= STOP;
                            end
                        end else begin
                            tx_serial <= shift_reg[0];
                            par_acc   <= par_acc ^ shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                PAR: begin
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        tx_serial <= 1'b1;
                        stop_idx  <= 1'b0;
                        state     <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (stop_idx != STOP_LAST) begin
                            stop_idx <= 1'b1;
                        end else if (stop_req) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (byte_idx != BYTE_LAST) begin
                            byte_idx  <= byte_idx + BYTE_W'(1);
                            tx_serial <= 1'b0;
                            state     <= START;
                        end else if (more_words) begin
                            word_idx  <= next_idx[COUNT_W-1:0];
                            mem_addr  <= ADDR_WIDTH'(next_idx[COUNT_W-1:0]);
                            mem_rd_en <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    abort_flag <= 1'b0;
                    tx_serial  <= 1'b1;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_streamer.sv
// ============================================================================
// tb_uart_result_streamer
//
// Purpose:
//   Self-checking bench for uart_result_streamer. Three instances cover the
//   configurations of interest (all at 4 clocks per bit):
//     dut 0 : 8-bit words,  no parity,   1 stop bit,  memory latency 1
//     dut 1 : 16-bit words, even parity, 2 stop bits, memory latency 2
//     dut 2 : 8-bit words,  odd parity,  2 stop bits, memory latency 1
//   Only one instance is started at a time; the others must stay idle.
//
// Ports: none (top-level bench).
// ============================================================================
module tb_uart_result_streamer;

    localparam int CPB = 4;

    typedef struct packed {
        logic        tx;
        logic        busy;
        logic        done;
        logic        rd;
        logic [15:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v;
    logic [2:0]  abort_v;
    logic [7:0]  height;
    logic [7:0]  width;

    logic [15:0] a_addr, b_addr, c_addr;
    logic        a_rd, b_rd, c_rd;
    logic        a_tx, b_tx, c_tx;
    logic        a_busy, b_busy, c_busy;
    logic        a_done, b_done, c_done;
    logic [7:0]  a_rdata, c_rdata;
    logic [15:0] b_rdata, b_stage;

    logic [15:0] mem [256];

    exp_t        exp_q [$];
    logic [7:0]  rx_q [$];
    logic [7:0]  rxp_q [$];
    logic [7:0]  want [$];

    int          sel;
    int          n_compared;
    int          n_mismatched;
    int          rd_count;
    int          done_count;
    int          last_len;

    int          cfg_bytes [3] = '{1, 2, 1};
    int          cfg_lat   [3] = '{1, 2, 1};
    int          cfg_par   [3] = '{0, 1, 2};
    int          cfg_stop  [3] = '{1, 2, 2};

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    uart_result_streamer #(
        .CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .DIM_WIDTH(8), .ADDR_WIDTH(16),
        .MEM_LATENCY(1), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .height(height), .width(width), .mem_addr(a_addr), .mem_rd_en(a_rd),
        .mem_rdata(a_rdata), .tx_serial(a_tx), .busy(a_busy), .done(a_done)
    );

    uart_result_streamer #(
        .CLKS_PER_BIT(CPB), .DATA_WIDTH(16), .DIM_WIDTH(8), .ADDR_WIDTH(16),
        .MEM_LATENCY(2), .PARITY(1), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .height(height), .width(width), .mem_addr(b_addr), .mem_rd_en(b_rd),
        .mem_rdata(b_rdata), .tx_serial(b_tx), .busy(b_busy), .done(b_done)
    );

    uart_result_streamer #(
        .CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .DIM_WIDTH(8), .ADDR_WIDTH(16),
        .MEM_LATENCY(1), .PARITY(2), .STOP_BITS(2)
    ) dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]),
        .height(height), .width(width), .mem_addr(c_addr), .mem_rd_en(c_rd),
        .mem_rdata(c_rdata), .tx_serial(c_tx), .busy(c_busy), .done(c_done)
    );

    // Output memories: one-clock latency for A and C, a two-stage pipe for B
    always @(posedge clk) begin
        if (a_rd) a_rdata <= mem[a_addr[7:0]][7:0];
        if (c_rd) c_rdata <= mem[c_addr[7:0]][7:0];
        if (b_rd) b_stage <= mem[b_addr[7:0]];
        b_rdata <= b_stage;
    end

    function automatic logic [3:0] ctrlOf(input int d);
        case (d)
            0:       return {a_tx, a_busy, a_done, a_rd};
            1:       return {b_tx, b_busy, b_done, b_rd};
            default: return {c_tx, c_busy, c_done, c_rd};
        endcase
    endfunction

    function automatic logic [15:0] addrOf(input int d);
        case (d)
            0:       return a_addr;
            1:       return b_addr;
            default: return c_addr;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkQueue(input string tag, input logic [7:0] got [$],
                              input logic [7:0] exp_b [$]);
        checkOutput({tag, " count"}, got.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", tag, i),
                        (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_b[i]));
        end
    endtask

    // Model: holds one line-level bit for CPB cycles while the dump is busy
    task automatic pushBit(input logic bitval, input int w);
        exp_t e;
        e.tx = bitval; e.busy = 1'b1; e.done = 1'b0; e.rd = 1'b0; e.addr = 16'(w);
        repeat (CPB) exp_q.push_back(e);
    endtask

    // Model: the expected per-cycle outputs of a whole dump, starting with the
    // cycle right after the edge that accepts start. Each word costs one read
    // cycle plus the memory latency of idle line, then its byte frames. The
    // dump ends after max_frames frames if an abort is planned.
    task automatic buildExpected(input int d, input int total, input int max_frames);
        exp_t       e;
        int         frames;
        bit         stopping;
        logic [7:0] bval;
        logic [15:0] word;
        exp_q.delete();
        frames   = 0;
        stopping = 1'b0;
        for (int w = 0; w < total && !stopping; w++) begin
            e.tx = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.rd = 1'b1; e.addr = 16'(w);
            exp_q.push_back(e);
            e.rd = 1'b0;
            repeat (cfg_lat[d]) exp_q.push_back(e);
            word = mem[w];
            for (int b = 0; b < cfg_bytes[d] && !stopping; b++) begin
                bval = word[8*b +: 8];
                pushBit(1'b0, w);
                for (int i = 0; i < 8; i++) pushBit(bval[i], w);
                if (cfg_par[d] == 1) pushBit(^bval, w);
                if (cfg_par[d] == 2) pushBit(~^bval, w);
                repeat (cfg_stop[d]) pushBit(1'b1, w);
                frames++;
                if (frames == max_frames) stopping = 1'b1;
            end
        end
        e.tx = 1'b1; e.busy = 1'b1; e.done = 1'b1; e.rd = 1'b0; e.addr = 16'd0;
        exp_q.push_back(e);
    endtask

    // Compare process: every falling edge, the selected instance must match
    // the head of the model queue; all other instances (and the selected one
    // once the queue is empty) must sit idle with the line high.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] ctrl;
        for (int d = 0; d < 3; d++) begin
            if (d == sel && exp_q.size() > 0) begin
                e = exp_q[0];
            end else begin
                e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.rd = 1'b0; e.addr = 16'd0;
            end
            ctrl = ctrlOf(d);
            checkOutput($sformatf("dut%0d {tx,busy,done,rd_en}", d), 32'(ctrl),
                        32'({e.tx, e.busy, e.done, e.rd}));
            if (e.rd) checkOutput($sformatf("dut%0d mem_addr", d), 32'(addrOf(d)), 32'(e.addr));
        end
        ctrl = ctrlOf(sel);
        if (ctrl[0]) rd_count++;
        if (ctrl[1]) done_count++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    end

    // UART receiver on the selected instance's line: finds the falling edge
    // of a start bit and samples data and parity in the middle of each bit.
    int         rx_cnt;
    bit         rx_active;
    logic [7:0] rx_byte;
    logic       rx_pbit;
    always @(negedge clk) begin
        logic line;
        int   rx_len;
        line   = ctrlOf(sel) >> 3;
        rx_len = CPB * (9 + ((cfg_par[sel] != 0) ? 1 : 0) + cfg_stop[sel]);
        if (rst) begin
            rx_active = 1'b0;
        end else if (rx_active) begin
            rx_cnt++;
            for (int i = 0; i < 8; i++) begin
                if (rx_cnt == CPB * (1 + i) + CPB / 2) rx_byte[i] = line;
            end
            if (rx_cnt == CPB * 9 + CPB / 2) rx_pbit = line;
            if (rx_cnt == rx_len - 1) begin
                rx_active = 1'b0;
                rx_q.push_back(rx_byte);
                if (cfg_par[sel] != 0) rxp_q.push_back({7'd0, rx_pbit});
            end
        end else if (line == 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
            rx_byte   = 8'h00;
        end
    end

    // Runs one dump on instance d and waits (bounded) for the model to drain.
    // Optional one-cycle abort and busy-time start pulses land on the given
    // cycle numbers counted from the accepting edge.
    task automatic applyStimulus(input int d, input int h, input int w, input int max_frames,
                                 input int abort_cyc, input int busy_start_cyc,
                                 input bit abort_with_start);
        int c;
        sel = d;
        rx_q.delete();
        rxp_q.delete();
        rd_count   = 0;
        done_count = 0;
        height     = 8'(h);
        width      = 8'(w);
        start_v[d] = 1'b1;
        abort_v[d] = abort_with_start;
        @(posedge clk);
        #1;
        start_v = '0;
        abort_v = '0;
        buildExpected(d, h * w, max_frames);
        last_len = exp_q.size();
        height   = 8'd7;
        width    = 8'd9;
        c = 0;
        while (exp_q.size() > 0 && c < 2000) begin
            start_v[d] = (c == busy_start_cyc);
            abort_v[d] = (c == abort_cyc);
            @(posedge clk);
            #1;
            c++;
        end
        start_v = '0;
        abort_v = '0;
        checkOutput("dump drained within budget", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        sel          = 0;
        start_v      = '0;
        abort_v      = '0;
        height       = '0;
        width        = '0;
        rx_active    = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset dut0 ctrl", 32'(ctrlOf(0)), 32'b1000);
        checkOutput("reset dut1 ctrl", 32'(ctrlOf(1)), 32'b1000);
        checkOutput("reset dut2 ctrl", 32'(ctrlOf(2)), 32'b1000);
        checkOutput("reset dut0 addr", 32'(a_addr), 0);
        checkOutput("reset dut1 addr", 32'(b_addr), 0);
        checkOutput("reset dut2 addr", 32'(c_addr), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 2x3 dump of 8-bit words, start arriving together with abort
        applyStimulus(0, 2, 3, 1000, -1, -1, 1'b1);
        checkOutput("t1 model length", last_len, 253);
        want = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        checkQueue("t1 rx", rx_q, want);
        checkOutput("t1 reads", rd_count, 6);
        checkOutput("t1 done pulses", done_count, 1);

        // Empty image: straight to done, no reads, line untouched
        applyStimulus(0, 0, 5, 1000, -1, -1, 1'b0);
        checkOutput("t2 model length", last_len, 1);
        checkOutput("t2 reads", rd_count, 0);
        checkOutput("t2 done pulses", done_count, 1);
        checkOutput("t2 rx frames", rx_q.size(), 0);

        // 4x4 dump, abort in the middle of frame 3, stray start while busy
        applyStimulus(0, 4, 4, 3, 99, 50, 1'b0);
        checkOutput("t3 model length", last_len, 127);
        want = {8'h00, 8'h01, 8'h02};
        checkQueue("t3 rx", rx_q, want);
        checkOutput("t3 reads", rd_count, 3);
        checkOutput("t3 done pulses", done_count, 1);

        // 16-bit word split into two back-to-back frames, even parity
        mem[0] = 16'hA55A;
        applyStimulus(1, 1, 1, 1000, -1, -1, 1'b0);
        checkOutput("t4 model length", last_len, 100);
        want = {8'h5A, 8'hA5};
        checkQueue("t4 rx", rx_q, want);
        want = {8'h00, 8'h00};
        checkQueue("t4 parity", rxp_q, want);

        // Even parity of 0x07 and 0x00
        mem[0] = 16'h0007;
        applyStimulus(1, 1, 1, 1000, -1, -1, 1'b0);
        want = {8'h07, 8'h00};
        checkQueue("t5 rx", rx_q, want);
        want = {8'h01, 8'h00};
        checkQueue("t5 parity", rxp_q, want);

        // Odd parity of 0x07
        applyStimulus(2, 1, 1, 1000, -1, -1, 1'b0);
        checkOutput("t6 model length", last_len, 51);
        want = {8'h07};
        checkQueue("t6 rx", rx_q, want);
        want = {8'h00};
        checkQueue("t6 parity", rxp_q, want);

        // Reset in the middle of a data bit, then a clean dump from address 0
        mem[0] = 16'h0000;
        sel    = 0;
        height = 8'd2;
        width  = 8'd3;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        buildExpected(0, 6, 1000);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("t7 tx after mid-frame reset", 32'(a_tx), 1);
        checkOutput("t7 busy after mid-frame reset", 32'(a_busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(0, 1, 2, 1000, -1, -1, 1'b0);
        checkOutput("t7 model length", last_len, 85);
        want = {8'h00, 8'h01};
        checkQueue("t7 rx", rx_q, want);
        checkOutput("t7 reads", rd_count, 2);
        checkOutput("t7 done pulses", done_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
